decode_stage: RTL and testbench

- Instruction-decode stage directly upstream of the execute stage.
- Decodes the 32-bit MIPS instruction, reads a 32x32 register file with writeback bypass, and generates ALU/extender/mux controls.
- Detects load-use hazards and registers all results into an ID/EX pipeline register that drives the execute stage inputs one cycle later.
- Handles stall, downstream hold and flush.

---
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch/writeback-to-decode and decode-to-execute signal bundle for decode_stage.
// The master drives the i_* side; decode_stage takes the slave view.
interface decode_stage_if;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        i_flush;
    logic        i_hold;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_stall;
    logic        o_valid;
    logic [25:0] o_imm;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic        o_ALUSrc_op1;
    logic        o_ALUSrc_op2;
    logic [5:0]  o_ALUCtrl;
    logic        o_extOp;
    logic        o_regWrite;
    logic        o_memRead;
    logic        o_memWrite;
    logic [4:0]  o_wrAddr;
    logic        o_illegal;

    modport master (
        output i_instr, i_instr_valid, i_flush, i_hold, i_wb_we, i_wb_addr, i_wb_data,
        input  o_stall, o_valid, o_imm, o_op1, o_op2, o_ALUSrc_op1, o_ALUSrc_op2,
               o_ALUCtrl, o_extOp, o_regWrite, o_memRead, o_memWrite, o_wrAddr, o_illegal
    );

    modport slave (
        input  i_instr, i_instr_valid, i_flush, i_hold, i_wb_we, i_wb_addr, i_wb_data,
        output o_stall, o_valid, o_imm, o_op1, o_op2, o_ALUSrc_op1, o_ALUSrc_op2,
               o_ALUCtrl, o_extOp, o_regWrite, o_memRead, o_memWrite, o_wrAddr, o_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: regfile read with writeback bypass, control decode, load-use stall, ID/EX register.
// Latency 1 cycle; flush > hold > load-use hazard > idle bubble > load; o_stall is combinational.
module decode_stage #(
    parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    decode_stage_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic [25:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        src_op1;
        logic        src_op2;
        logic [5:0]  alu_ctrl;
        logic        ext_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  wr_addr;
        logic        illegal;
    } idex_t;

    logic [31:0] r_rf [32];
    idex_t       r_idex;

    idex_t       w_dec;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_legal;
    logic        w_reads_rt;
    logic        w_hazard;

    assign w_op    = bus.i_instr[31:26];
    assign w_rs    = bus.i_instr[25:21];
    assign w_rt    = bus.i_instr[20:16];
    assign w_rd    = bus.i_instr[15:11];
    assign w_funct = bus.i_instr[5:0];

    // r0 is hardwired to zero and never bypassed.
    always_comb begin
        w_rs_val = r_rf[w_rs];
        if (w_rs == 5'd0)
            w_rs_val = 32'h0;
        else if (bus.i_wb_we && bus.i_wb_addr == w_rs)
            w_rs_val = bus.i_wb_data;
        w_rt_val = r_rf[w_rt];
        if (w_rt == 5'd0)
            w_rt_val = 32'h0;
        else if (bus.i_wb_we && bus.i_wb_addr == w_rt)
            w_rt_val = bus.i_wb_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++)
                r_rf[i] <= (i == 0) ? 32'h0 : REG_RESET_VAL;
        end else if (bus.i_wb_we && bus.i_wb_addr != 5'd0) begin
            r_rf[bus.i_wb_addr] <= bus.i_wb_data;
        end
    end

    always_comb begin
        w_dec       = '0;
        w_legal     = 1'b0;
        w_dec.valid = 1'b1;
        w_dec.imm   = bus.i_instr[25:0];
        w_dec.op1   = w_rs_val;
        w_dec.op2   = w_rt_val;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: w_legal = 1'b1;
                    6'h00, 6'h02, 6'h03: begin
                        w_legal       = 1'b1;
                        w_dec.src_op1 = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
                w_dec.alu_ctrl  = w_funct;
                w_dec.wr_addr   = w_rd;
                w_dec.reg_write = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                w_legal         = 1'b1;
                w_dec.src_op2   = 1'b1;
                w_dec.wr_addr   = w_rt;
                w_dec.reg_write = 1'b1;
                w_dec.ext_op    = (w_op <= 6'h0B);
                case (w_op)
                    6'h08:   w_dec.alu_ctrl = 6'h20;
                    6'h09:   w_dec.alu_ctrl = 6'h21;
                    6'h0A:   w_dec.alu_ctrl = 6'h2A;
                    6'h0B:   w_dec.alu_ctrl = 6'h2B;
                    6'h0C:   w_dec.alu_ctrl = 6'h24;
                    6'h0D:   w_dec.alu_ctrl = 6'h25;
                    default: w_dec.alu_ctrl = 6'h26;
                endcase
            end
            6'h23: begin
                w_legal         = 1'b1;
                w_dec.alu_ctrl  = 6'h21;
                w_dec.ext_op    = 1'b1;
                w_dec.src_op2   = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wr_addr   = w_rt;
            end
            6'h2B: begin
                w_legal         = 1'b1;
                w_dec.alu_ctrl  = 6'h21;
                w_dec.ext_op    = 1'b1;
                w_dec.src_op2   = 1'b1;
                w_dec.mem_write = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        // An unsupported encoding still occupies one slot as a flagged bubble.
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
    end

    // Only R-type and sw consume rt as a source; I-type ALU ops write it.
    assign w_reads_rt = (w_op == 6'h00) || (w_op == 6'h2B);
    assign w_hazard   = r_idex.valid && r_idex.mem_read && (r_idex.wr_addr != 5'd0) &&
                        ((r_idex.wr_addr == w_rs) || ((r_idex.wr_addr == w_rt) && w_reads_rt));

    assign bus.o_stall = !i_rst && !bus.i_flush && (bus.i_hold || w_hazard);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_idex <= '0;
        else if (bus.i_flush)
            r_idex <= '0;
        else if (bus.i_hold)
            r_idex <= r_idex;
        else if (w_hazard || !bus.i_instr_valid)
            r_idex <= '0;
        else
            r_idex <= w_dec;
    end

    assign bus.o_valid      = r_idex.valid;
    assign bus.o_imm        = r_idex.imm;
    assign bus.o_op1        = r_idex.op1;
    assign bus.o_op2        = r_idex.op2;
    assign bus.o_ALUSrc_op1 = r_idex.src_op1;
    assign bus.o_ALUSrc_op2 = r_idex.src_op2;
    assign bus.o_ALUCtrl    = r_idex.alu_ctrl;
    assign bus.o_extOp      = r_idex.ext_op;
    assign bus.o_regWrite   = r_idex.reg_write;
    assign bus.o_memRead    = r_idex.mem_read;
    assign bus.o_memWrite   = r_idex.mem_write;
    assign bus.o_wrAddr     = r_idex.wr_addr;
    assign bus.o_illegal    = r_idex.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus bypass, load-use, hold/flush and reset sequences.
module tb_decode_stage;
    logic i_clk;
    logic i_rst;
    decode_stage_if bus ();

    decode_stage #(.REG_RESET_VAL(32'h0000_00FF)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        valid;
        logic [25:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        s1;
        logic        s2;
        logic [5:0]  alu;
        logic        ext;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [4:0]  wr;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        out_t        exp;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs [12];
    out_t zero_out;
    out_t ill_out;
    out_t add_r4;

    function automatic out_t mk(logic [25:0] imm, logic [31:0] op1, logic [31:0] op2,
                                logic s1, logic s2, logic [5:0] alu, logic ext,
                                logic rw, logic mr, logic mw, logic [4:0] wr);
        out_t o;
        o = '{valid: 1'b1, imm: imm, op1: op1, op2: op2, s1: s1, s2: s2, alu: alu,
              ext: ext, rw: rw, mr: mr, mw: mw, wr: wr, ill: 1'b0};
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o = '{valid: bus.o_valid, imm: bus.o_imm, op1: bus.o_op1, op2: bus.o_op2,
              s1: bus.o_ALUSrc_op1, s2: bus.o_ALUSrc_op2, alu: bus.o_ALUCtrl,
              ext: bus.o_extOp, rw: bus.o_regWrite, mr: bus.o_memRead,
              mw: bus.o_memWrite, wr: bus.o_wrAddr, ill: bus.o_illegal};
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.i_wb_we = 1'b1; bus.i_wb_addr = a; bus.i_wb_data = d;
        tick();
        bus.i_wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.i_instr = ins; bus.i_instr_valid = 1'b1;
    endtask

    task automatic idle();
        bus.i_instr = 32'h0; bus.i_instr_valid = 1'b0;
    endtask

    initial begin
        zero_out = '0;
        ill_out  = '0;
        ill_out.ill = 1'b1;
        add_r4 = mk(26'h0602020, 32'hDEAD_BEEF, 32'h0, 0, 0, 6'h20, 0, 1, 0, 0, 5'd4);

        vecs[0]  = '{32'h20A6FFFF, mk(26'h0A6FFFF, 32'h1234, 32'hFF, 0, 1, 6'h20, 1, 1, 0, 0, 5'd6)};
        vecs[1]  = '{32'h00083900, mk(26'h0083900, 32'h0, 32'h80, 1, 0, 6'h00, 0, 1, 0, 0, 5'd7)};
        vecs[2]  = '{32'h012A5822, mk(26'h12A5822, 32'hA5A5_0000, 32'h0F0F, 0, 0, 6'h22, 0, 1, 0, 0, 5'd11)};
        vecs[3]  = '{32'h314C8001, mk(26'h14C8001, 32'h0F0F, 32'hFF, 0, 1, 6'h24, 0, 1, 0, 0, 5'd12)};
        vecs[4]  = '{32'h8C220008, mk(26'h0220008, 32'h100, 32'hFF, 0, 1, 6'h21, 1, 1, 1, 0, 5'd2)};
        vecs[5]  = '{32'hAC2A0004, mk(26'h02A0004, 32'h100, 32'h0F0F, 0, 1, 6'h21, 1, 0, 0, 1, 5'd0)};
        vecs[6]  = '{32'hFC000000, ill_out};
        vecs[7]  = '{32'h00000028, ill_out};
        vecs[8]  = '{32'h2C030007, mk(26'h0030007, 32'h0, 32'hFF, 0, 1, 6'h2B, 1, 1, 0, 0, 5'd3)};
        vecs[9]  = '{32'h00A96827, mk(26'h0A96827, 32'h1234, 32'hA5A5_0000, 0, 0, 6'h27, 0, 1, 0, 0, 5'd13)};
        vecs[10] = '{32'h392EFFFF, mk(26'h12EFFFF, 32'hA5A5_0000, 32'hFF, 0, 1, 6'h26, 0, 1, 0, 0, 5'd14)};
        vecs[11] = '{32'h00097FC3, mk(26'h0097FC3, 32'h0, 32'hA5A5_0000, 1, 0, 6'h03, 0, 1, 0, 0, 5'd15)};

        i_rst = 1'b1;
        idle();
        bus.i_flush = 1'b0; bus.i_hold = 1'b0;
        bus.i_wb_we = 1'b0; bus.i_wb_addr = 5'd0; bus.i_wb_data = 32'h0;
        #1;
        chk("reset_idex", 128'(cur()), 128'(zero_out));
        chk("reset_stall", 128'(bus.o_stall), 128'(1'b0));
        tick(); tick();
        i_rst = 1'b0;

        wb(5'd5, 32'h1234);
        wb(5'd1, 32'h100);
        wb(5'd8, 32'h80);
        wb(5'd9, 32'hA5A5_0000);
        wb(5'd10, 32'h0F0F);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].instr);
            tick();
            chk($sformatf("vec%0d", i), 128'(cur()), 128'(vecs[i].exp));
            idle();
            tick();
            chk($sformatf("vec%0d_bubble", i), 128'(cur()), 128'(zero_out));
        end

        // Same-cycle bypass, and r0 ignoring both writes and bypass.
        bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd3; bus.i_wb_data = 32'hDEAD_BEEF;
        issue(32'h00602020);
        tick();
        chk("bypass_rs", 128'(cur()), 128'(add_r4));
        bus.i_wb_addr = 5'd0; bus.i_wb_data = 32'hFFFF_FFFF;
        issue(32'h00002020);
        tick();
        bus.i_wb_we = 1'b0;
        chk("r0_bypass", 128'(cur()), 128'(mk(26'h0002020, 0, 0, 0, 0, 6'h20, 0, 1, 0, 0, 5'd4)));
        tick();
        chk("r0_read", 128'(cur()), 128'(mk(26'h0002020, 0, 0, 0, 0, 6'h20, 0, 1, 0, 0, 5'd4)));
        idle(); tick();

        // Load-use on rs: one stall cycle, one bubble, then the add issues.
        issue(32'h8C220000); tick();
        issue(32'h00421820); #1;
        chk("lu_stall", 128'(bus.o_stall), 128'(1'b1));
        tick();
        chk("lu_bubble", 128'(bus.o_valid), 128'(1'b0));
        chk("lu_resolved", 128'(bus.o_stall), 128'(1'b0));
        tick();
        chk("lu_issue", 128'(cur()), 128'(mk(26'h0421820, 32'hFF, 32'hFF, 0, 0, 6'h20, 0, 1, 0, 0, 5'd3)));
        idle(); tick();

        // Load-use on rt only (R-type reads rt).
        issue(32'h8C220000); tick();
        issue(32'h00221822); #1;
        chk("lu_rt_stall", 128'(bus.o_stall), 128'(1'b1));
        tick(); idle(); tick();

        // ori writes rt==load dest, so it does not read it: no stall.
        issue(32'h8C220000); tick();
        issue(32'h34220005); #1;
        chk("ori_no_stall", 128'(bus.o_stall), 128'(1'b0));
        tick();
        chk("ori_issue", 128'(cur()), 128'(mk(26'h0220005, 32'h100, 32'hFF, 0, 1, 6'h25, 0, 1, 0, 0, 5'd2)));
        idle(); tick();

        // Hold freezes ID/EX for three cycles while writeback proceeds.
        issue(32'h00602020); tick();
        chk("hold_load", 128'(cur()), 128'(add_r4));
        issue(32'h00221822);
        bus.i_hold = 1'b1;
        bus.i_wb_we = 1'b1; bus.i_wb_addr = 5'd20; bus.i_wb_data = 32'h55AA;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_stall%0d", k), 128'(bus.o_stall), 128'(1'b1));
            tick();
            bus.i_wb_we = 1'b0;
            chk($sformatf("hold_keep%0d", k), 128'(cur()), 128'(add_r4));
        end
        bus.i_flush = 1'b1; #1;
        chk("flush_hold_stall", 128'(bus.o_stall), 128'(1'b0));
        tick();
        chk("flush_hold_bubble", 128'(cur()), 128'(zero_out));
        bus.i_flush = 1'b0; bus.i_hold = 1'b0;
        issue(32'h0280A820); tick();
        chk("wb_during_hold", 128'(cur()), 128'(mk(26'h280A820, 32'h55AA, 32'h0, 0, 0, 6'h20, 0, 1, 0, 0, 5'd21)));
        idle(); tick();

        // Flush overrides a load-use hazard.
        issue(32'h8C220000); tick();
        issue(32'h00421820); bus.i_flush = 1'b1; #1;
        chk("flush_hz_stall", 128'(bus.o_stall), 128'(1'b0));
        tick();
        chk("flush_hz_bubble", 128'(cur()), 128'(zero_out));
        bus.i_flush = 1'b0; idle(); tick();

        // Reset mid-stall clears everything immediately, including the regfile.
        issue(32'h8C220000); tick();
        issue(32'h00421820); #1;
        chk("rst_pre_stall", 128'(bus.o_stall), 128'(1'b1));
        i_rst = 1'b1; #1;
        chk("rst_mid_stall", 128'(bus.o_stall), 128'(1'b0));
        chk("rst_mid_idex", 128'(cur()), 128'(zero_out));
        tick();
        i_rst = 1'b0;
        issue(32'h00A02020); tick();
        chk("rst_regfile", 128'(cur()), 128'(mk(26'h0A02020, 32'hFF, 32'h0, 0, 0, 6'h20, 0, 1, 0, 0, 5'd4)));
        idle(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
